// File: rtl/msu_pkg.sv
// Shared types and constants for the MSU-1 data-port prefetcher.
//   fetch_state_t : sector fetch FSM encoding
//   bank_t        : index of one of the two sector buffer banks
//   SECTOR_BYTES  : bytes per sector fetched from the HPS
package msu_pkg;

    localparam int SECTOR_BYTES = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

    typedef logic bank_t;

endpackage

// File: rtl/msu_data_ram.sv
// Two-bank sector buffer: simple dual-port RAM, one write port (HPS side),
// one registered read port (SNES side), single clock. No reset on the array
// or the read register so it maps onto block RAM.
//   CLK      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address {bank, offset}
//   i_wdata  in   write data
//   i_raddr  in   read address {bank, offset}
//   o_rdata  out  read data, one cycle after i_raddr
module msu_data_ram #(
    parameter int AW = 10
) (
    input  logic          CLK,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [0:(2**AW)-1];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/msu_data_fetch.sv
// Sector-prefetching data responder for the MSU-1 data port. Keeps two
// 512-byte banks filled from the HPS block device and presents the byte at
// the current read position; reports busy while that byte is not yet loaded.
//   CLK, RST_N                      clock, async active-low reset
//   data_mounted                    data image present (0: no fetches, data 0x00)
//   msu_data_seek / msu_data_addr   load a new byte position
//   msu_data_req                    advance the position by one
//   msu_data_in                     byte at the current position
//   msu_status_data_busy            current byte not yet valid
//   sd_lba / sd_rd / sd_ack         HPS sector request handshake
//   sd_buff_addr/_dout/_wr          HPS sector byte stream
//
// Fetch FSM:
//   state | meaning
//   IDLE  | waiting for a bank that needs filling
//   REQ   | sd_rd high, waiting for sd_ack to rise
//   XFER  | HPS streaming bytes into the fill bank until sd_ack falls
//   DONE  | mark the fill bank valid unless a seek cancelled the transfer
module msu_data_fetch
    import msu_pkg::*;
#(
    parameter int SECTOR_BITS = 9
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   data_mounted,
    input  logic                   msu_data_seek,
    input  logic [31:0]            msu_data_addr,
    input  logic                   msu_data_req,
    output logic [7:0]             msu_data_in,
    output logic                   msu_status_data_busy,
    output logic [31:0]            sd_lba,
    output logic                   sd_rd,
    input  logic                   sd_ack,
    input  logic [SECTOR_BITS-1:0] sd_buff_addr,
    input  logic [7:0]             sd_buff_dout,
    input  logic                   sd_buff_wr
);

    localparam int LBA_W = 32 - SECTOR_BITS;

    fetch_state_t           r_state, w_state_nxt;
    bank_t                  r_act, r_fill_bank, w_other, w_issue_bank;
    logic [SECTOR_BITS-1:0] r_ptr;
    logic [1:0]             r_valid, w_valid_nxt;
    logic [1:0]             r_need, w_need_nxt;
    logic [LBA_W-1:0]       r_lba [0:1];
    logic                   r_busy, r_cancel, r_sd_rd, r_ack_d;
    logic [31:0]            r_sd_lba;
    logic [7:0]             r_data, w_ram_q;
    logic                   w_ack_rise, w_ack_fall, w_advance, w_wrap;
    logic                   w_issue, w_done_ok, w_we;

    assign w_ack_rise   = sd_ack & ~r_ack_d;
    assign w_ack_fall   = ~sd_ack & r_ack_d;
    assign w_other      = ~r_act;
    // Seek wins over a simultaneous req; reqs while busy are dropped.
    assign w_advance    = msu_data_req & ~msu_data_seek & ~r_busy;
    assign w_wrap       = w_advance & (&r_ptr);
    assign w_issue_bank = r_need[r_act] ? r_act : w_other;
    // Bytes may arrive in the same cycle ack rises; after a reset the FSM is
    // back in IDLE so stray strobes of an old transfer are ignored.
    assign w_we = sd_buff_wr & ((r_state == XFER) | ((r_state == REQ) & sd_ack));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done_ok   = 1'b0;
        case (r_state)
            IDLE: begin
                // A seek in this cycle rewrites the targets; wait for it.
                if (data_mounted && !msu_data_seek && (|r_need)) begin
                    w_issue     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ:  if (w_ack_rise) w_state_nxt = XFER;
            XFER: if (w_ack_fall) w_state_nxt = DONE;
            DONE: begin
                w_done_ok   = ~r_cancel;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_valid_nxt = r_valid;
        if (w_done_ok) w_valid_nxt[r_fill_bank] = 1'b1;
        if (w_wrap)    w_valid_nxt[r_act] = 1'b0;
        if (msu_data_seek) w_valid_nxt = 2'b00;

        w_need_nxt = r_need;
        if (w_issue) w_need_nxt[w_issue_bank] = 1'b0;
        if (w_wrap && data_mounted) w_need_nxt[r_act] = 1'b1;
        if (msu_data_seek) w_need_nxt = {2{data_mounted}};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ack_d     <= 1'b0;
            r_act       <= 1'b0;
            r_ptr       <= '0;
            r_valid     <= '0;
            r_need      <= '0;
            r_lba[0]    <= '0;
            r_lba[1]    <= '0;
            r_busy      <= 1'b0;
            r_cancel    <= 1'b0;
            r_fill_bank <= 1'b0;
            r_sd_lba    <= '0;
            r_sd_rd     <= 1'b0;
            r_data      <= '0;
        end else begin
            r_ack_d <= sd_ack;
            r_valid <= w_valid_nxt;
            r_need  <= w_need_nxt;
            r_data  <= data_mounted ? w_ram_q : 8'h00;

            if (msu_data_seek) begin
                r_act    <= 1'b0;
                r_ptr    <= msu_data_addr[SECTOR_BITS-1:0];
                r_lba[0] <= msu_data_addr[31:SECTOR_BITS];
                r_lba[1] <= msu_data_addr[31:SECTOR_BITS] + 1'b1;
            end else if (w_advance) begin
                r_ptr <= r_ptr + 1'b1;
                if (w_wrap) begin
                    r_act        <= w_other;
                    r_lba[r_act] <= r_lba[w_other] + 1'b1;
                end
            end

            // Busy covers the registered RAM read plus output register: it
            // only drops the cycle after the active bank is seen valid.
            if (msu_data_seek) begin
                r_busy <= data_mounted;
            end else if (w_wrap) begin
                r_busy <= data_mounted & ~w_valid_nxt[w_other];
            end else if (r_busy && (r_valid[r_act] || !data_mounted)) begin
                r_busy <= 1'b0;
            end

            // An in-flight HPS transfer cannot be aborted; its data is dropped.
            if (msu_data_seek && ((r_state == REQ) || (r_state == XFER))) begin
                r_cancel <= 1'b1;
            end else if (r_state == DONE) begin
                r_cancel <= 1'b0;
            end

            if (w_issue) begin
                r_fill_bank <= w_issue_bank;
                r_sd_lba    <= {{SECTOR_BITS{1'b0}}, r_lba[w_issue_bank]};
                r_sd_rd     <= 1'b1;
            end else if ((r_state == REQ) && w_ack_rise) begin
                r_sd_rd <= 1'b0;
            end
        end
    end

    msu_data_ram #(
        .AW (SECTOR_BITS + 1)
    ) u_ram (
        .CLK     (CLK),
        .i_we    (w_we),
        .i_waddr ({r_fill_bank, sd_buff_addr}),
        .i_wdata (sd_buff_dout),
        .i_raddr ({r_act, r_ptr}),
        .o_rdata (w_ram_q)
    );

    assign msu_data_in          = r_data;
    assign msu_status_data_busy = r_busy;
    assign sd_lba               = r_sd_lba;
    assign sd_rd                = r_sd_rd;

endmodule

// File: tb/tb_msu_data_fetch.sv
module tb_msu_data_fetch;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        data_mounted = 1'b1;
    logic        msu_data_seek = 1'b0;
    logic [31:0] msu_data_addr = '0;
    logic        msu_data_req = 1'b0;
    logic [7:0]  msu_data_in;
    logic        msu_status_data_busy;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_ack = 1'b0;
    logic [8:0]  sd_buff_addr = '0;
    logic [7:0]  sd_buff_dout = '0;
    logic        sd_buff_wr = 1'b0;

    msu_data_fetch #(.SECTOR_BITS(9)) dut (
        .CLK                  (CLK),
        .RST_N                (RST_N),
        .data_mounted         (data_mounted),
        .msu_data_seek        (msu_data_seek),
        .msu_data_addr        (msu_data_addr),
        .msu_data_req         (msu_data_req),
        .msu_data_in          (msu_data_in),
        .msu_status_data_busy (msu_status_data_busy),
        .sd_lba               (sd_lba),
        .sd_rd                (sd_rd),
        .sd_ack               (sd_ack),
        .sd_buff_addr         (sd_buff_addr),
        .sd_buff_dout         (sd_buff_dout),
        .sd_buff_wr           (sd_buff_wr)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] lba_log[$];
    logic [31:0] pos = '0;

    int          hps_st = 0;
    int          hps_cnt = 0;
    int          hps_delay = 10;
    int          hps_done = 0;
    logic [9:0]  hps_idx = '0;
    logic [31:0] hps_lba = '0;
    logic        busy_seen = 1'b0;
    logic        rd_seen = 1'b0;

    function automatic logic [7:0] expb(input logic [31:0] p);
        return p[16:9] ^ p[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // HPS block-device model: byte = lba[7:0] ^ offset[7:0]
    always @(negedge CLK) begin
        if (msu_status_data_busy) busy_seen = 1'b1;
        if (sd_rd) rd_seen = 1'b1;
        if (!RST_N) begin
            hps_st = 0;
            sd_ack = 1'b0;
            sd_buff_wr = 1'b0;
        end else begin
            case (hps_st)
                0: begin
                    sd_buff_wr = 1'b0;
                    if (sd_rd) begin
                        hps_lba = sd_lba;
                        lba_log.push_back(sd_lba);
                        hps_cnt = hps_delay;
                        hps_st = 1;
                    end
                end
                1: begin
                    if (hps_cnt == 0) begin
                        check("lba_stable", sd_lba, hps_lba);
                        sd_ack = 1'b1;
                        hps_idx = '0;
                        hps_st = 2;
                    end else begin
                        hps_cnt--;
                    end
                end
                2: begin
                    sd_buff_wr = 1'b1;
                    sd_buff_addr = hps_idx[8:0];
                    sd_buff_dout = hps_lba[7:0] ^ hps_idx[7:0];
                    if (hps_idx == 10'd511) hps_st = 3;
                    else hps_idx = hps_idx + 1'b1;
                end
                default: begin
                    sd_buff_wr = 1'b0;
                    sd_ack = 1'b0;
                    hps_done++;
                    hps_st = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_seek(input logic [31:0] a);
        msu_data_addr = a;
        msu_data_seek = 1'b1;
        tick();
        msu_data_seek = 1'b0;
        pos = a;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (msu_status_data_busy === 1'b1 && n < 20000) begin
            tick();
            n++;
        end
        check({tag, "_busy_timeout"}, {31'd0, msu_status_data_busy}, 32'd0);
        tick();
        tick();
    endtask

    task automatic advance(input int gap);
        msu_data_req = 1'b1;
        tick();
        msu_data_req = 1'b0;
        pos = pos + 1;
        exp_q.push_back(expb(pos));
        wait_ready("adv");
        check("adv_data", {24'd0, msu_data_in}, {24'd0, exp_q.pop_front()});
        repeat (gap) tick();
    endtask

    task automatic wait_quiet();
        int q = 0;
        int n = 0;
        while (q < 8 && n < 20000) begin
            tick();
            n++;
            if (hps_st == 0 && sd_rd == 1'b0) q++;
            else q = 0;
        end
        check("quiet_timeout", q, 8);
    endtask

    task automatic wait_xfer();
        int n = 0;
        while (hps_st != 2 && n < 20000) begin
            tick();
            n++;
        end
        check("xfer_timeout", hps_st, 2);
    endtask

    initial begin
        int d0;
        repeat (3) tick();
        check("rst_data", {24'd0, msu_data_in}, 32'd0);
        check("rst_busy", {31'd0, msu_status_data_busy}, 32'd0);
        check("rst_rd", {31'd0, sd_rd}, 32'd0);
        check("rst_lba", sd_lba, 32'd0);
        RST_N = 1'b1;
        tick();

        // Seek 0x203: lba 1 then lba 2, byte 0x02
        hps_delay = 10;
        lba_log.delete();
        d0 = hps_done;
        do_seek(32'h0000_0203);
        exp_q.push_back(8'h02);
        check("t1_busy_rise", {31'd0, msu_status_data_busy}, 32'd1);
        tick();
        check("t1_rd_rise", {31'd0, sd_rd}, 32'd1);
        check("t1_lba_first", sd_lba, 32'd1);
        wait_ready("t1");
        check("t1_one_sector", hps_done - d0, 1);
        check("t1_data", {24'd0, msu_data_in}, {24'd0, exp_q.pop_front()});
        wait_quiet();
        check("t1_log0", lba_log[0], 32'd1);
        check("t1_log1", lba_log[1], 32'd2);

        // 600 spaced reads from 0 across the bank wrap
        hps_delay = 20;
        lba_log.delete();
        do_seek(32'h0);
        exp_q.push_back(expb(32'h0));
        wait_ready("t2");
        check("t2_data0", {24'd0, msu_data_in}, {24'd0, exp_q.pop_front()});
        busy_seen = 1'b0;
        for (int i = 0; i < 600; i++) advance(1);
        check("t2_no_busy", {31'd0, busy_seen}, 32'd0);
        wait_quiet();
        check("t2_refill_lba", lba_log[2], 32'd2);

        // 1024 back-to-back reads with a slow HPS
        hps_delay = 5000;
        lba_log.delete();
        do_seek(32'h0);
        exp_q.push_back(expb(32'h0));
        wait_ready("t3");
        check("t3_data0", {24'd0, msu_data_in}, {24'd0, exp_q.pop_front()});
        for (int i = 1; i < 512; i++) advance(0);
        msu_data_req = 1'b1;
        tick();
        msu_data_req = 1'b0;
        pos = pos + 1;
        exp_q.push_back(expb(pos));
        check("t3_boundary_busy", {31'd0, msu_status_data_busy}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
            msu_data_req = 1'b1;
            tick();
            msu_data_req = 1'b0;
        end
        check("t3_busy_hold", {31'd0, msu_status_data_busy}, 32'd1);
        wait_ready("t3b");
        check("t3_resume", {24'd0, msu_data_in}, {24'd0, exp_q.pop_front()});
        for (int i = 513; i <= 1024; i++) advance(0);
        check("t3_pos", pos, 32'd1024);

        // Seek during XFER: first transfer discarded
        hps_delay = 10;
        wait_quiet();
        lba_log.delete();
        do_seek(32'h0000_1000);
        wait_xfer();
        repeat (50) tick();
        d0 = hps_done;
        do_seek(32'h0002_0005);
        exp_q.push_back(8'h05);
        begin
            int n = 0;
            while (hps_done == d0 && n < 2000) begin
                tick();
                n++;
            end
        end
        repeat (3) tick();
        check("t4_discard_busy", {31'd0, msu_status_data_busy}, 32'd1);
        wait_ready("t4");
        check("t4_data", {24'd0, msu_data_in}, {24'd0, exp_q.pop_front()});
        check("t4_log0", lba_log[0], 32'h8);
        check("t4_log1", lba_log[1], 32'h100);

        // Unmounted seek
        wait_quiet();
        data_mounted = 1'b0;
        rd_seen = 1'b0;
        busy_seen = 1'b0;
        do_seek(32'h0000_0403);
        repeat (20) tick();
        check("t5_no_rd", {31'd0, rd_seen}, 32'd0);
        check("t5_no_busy", {31'd0, busy_seen}, 32'd0);
        check("t5_data_zero", {24'd0, msu_data_in}, 32'd0);
        data_mounted = 1'b1;

        // Reset during XFER, then a fresh seek
        do_seek(32'h0000_1000);
        wait_xfer();
        repeat (30) tick();
        RST_N = 1'b0;
        #2;
        check("t6_rst_busy", {31'd0, msu_status_data_busy}, 32'd0);
        check("t6_rst_rd", {31'd0, sd_rd}, 32'd0);
        check("t6_rst_lba", sd_lba, 32'd0);
        check("t6_rst_data", {24'd0, msu_data_in}, 32'd0);
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        lba_log.delete();
        do_seek(32'h0000_0605);
        exp_q.push_back(8'h06);
        wait_ready("t6");
        check("t6_data", {24'd0, msu_data_in}, {24'd0, exp_q.pop_front()});
        check("t6_log0", lba_log[0], 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
